fp_add_scheduler: RTL and testbench

Round-robin scheduler that shares a single combinational `fp_adder` instance between `N_REQ` independent requesters. It accepts one add/sub request at a time over a valid/ready handshake and registers the operands into the adder. It then captures the adder result and returns it on a single response port, tagged with the requester index and held under backpressure. It sits between the FPU's client ports and the adder datapath and is the only block that drives the adder's inputs.

---
 rtl/fp_add_scheduler.sv | 164 ++++++++++++++++
 tb/tb_fp_add_scheduler.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_add_scheduler.sv
// rtl/fp_add_scheduler.sv - round-robin scheduler sharing one combinational fp adder
// Holds one op in flight: IDLE accepts, EXEC lets the adder settle, DONE holds the response.
module fp_adder (
  input  logic [31:0] num1_i,
  input  logic [31:0] num2_i,
  input  logic        add_sub_i,
  output logic [31:0] result_o
);
  logic        sign_a, sign_b, sign_l, sign_s;
  logic [7:0]  exp_a, exp_b, exp_l, exp_s;
  logic [23:0] man_a, man_b, man_l, man_s;
  logic [24:0] man_sh, mag;
  logic [4:0]  lz;
  logic [22:0] norm;

  always_comb begin
    sign_a = num1_i[31];
    sign_b = num2_i[31] ^ add_sub_i;
    exp_a  = num1_i[30:23];
    exp_b  = num2_i[30:23];
    man_a  = (exp_a != 8'd0) ? {1'b1, num1_i[22:0]} : 24'd0;
    man_b  = (exp_b != 8'd0) ? {1'b1, num2_i[22:0]} : 24'd0;
    // Larger magnitude first so alignment only ever shifts right and the sign comes from it.
    if ({exp_a, man_a} >= {exp_b, man_b}) begin
      sign_l = sign_a; exp_l = exp_a; man_l = man_a;
      sign_s = sign_b; exp_s = exp_b; man_s = man_b;
    end else begin
      sign_l = sign_b; exp_l = exp_b; man_l = man_b;
      sign_s = sign_a; exp_s = exp_a; man_s = man_a;
    end
    man_sh = {1'b0, man_s} >> (exp_l - exp_s);
    mag    = (sign_l == sign_s) ? ({1'b0, man_l} + man_sh) : ({1'b0, man_l} - man_sh);
    lz     = 5'd0;
    for (int i = 0; i < 24; i++) begin
      if (mag[i]) lz = 5'(23 - i);
    end
    norm = mag[22:0] << lz;
    if (mag == 25'd0)
      result_o = 32'd0;
    else if (mag[24])
      result_o = {sign_l, exp_l + 8'd1, mag[23:1]};
    else
      result_o = {sign_l, exp_l - {3'b000, lz}, norm};
  end
endmodule

module fp_add_scheduler #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [32*N_REQ-1:0]  req_num1,
  input  logic [32*N_REQ-1:0]  req_num2,
  input  logic [N_REQ-1:0]     req_add_sub,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic [31:0]          rsp_result,
  output logic                 busy
);
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [ID_W-1:0] rr_q, rr_d, id_q, id_d;
  logic [31:0]     num1_q, num1_d, num2_q, num2_d, res_q, res_d;
  logic            sub_q, sub_d;
  logic [31:0]     add_result;
  logic [31:0]     num1_arr [N_REQ];
  logic [31:0]     num2_arr [N_REQ];
  logic            grant_vld;
  logic [ID_W-1:0] grant_idx, rr_cand;
  logic [ID_W:0]   rr_sum;

  for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
    assign num1_arr[i] = req_num1[32*i +: 32];
    assign num2_arr[i] = req_num2[32*i +: 32];
  end

  fp_adder u_adder (
    .num1_i    (num1_q),
    .num2_i    (num2_q),
    .add_sub_i (sub_q),
    .result_o  (add_result)
  );

  // Walk the search order backwards so the first valid requester after rr_q wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    rr_sum    = '0;
    rr_cand   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      rr_sum = {1'b0, rr_q} + (ID_W+1)'(k);
      if (rr_sum >= (ID_W+1)'(N_REQ)) rr_sum = rr_sum - (ID_W+1)'(N_REQ);
      rr_cand = rr_sum[ID_W-1:0];
      if (req_valid[rr_cand]) begin
        grant_vld = 1'b1;
        grant_idx = rr_cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      rr_q    <= '0;
      id_q    <= '0;
      num1_q  <= '0;
      num2_q  <= '0;
      sub_q   <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      id_q    <= id_d;
      num1_q  <= num1_d;
      num2_q  <= num2_d;
      sub_q   <= sub_d;
      res_q   <= res_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    id_d    = id_q;
    num1_d  = num1_q;
    num2_d  = num2_q;
    sub_d   = sub_q;
    res_d   = res_q;
    case (state_q)
      S_IDLE: begin
        if (grant_vld) begin
          state_d = S_EXEC;
          rr_d    = (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
          id_d    = grant_idx;
          num1_d  = num1_arr[grant_idx];
          num2_d  = num2_arr[grant_idx];
          sub_d   = req_add_sub[grant_idx];
        end
      end
      S_EXEC: begin
        res_d   = add_result;
        state_d = S_DONE;
      end
      S_DONE: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    if (state_q == S_IDLE && grant_vld && !rst) req_ready[grant_idx] = 1'b1;
    rsp_valid  = (state_q == S_DONE);
    rsp_id     = (state_q == S_DONE) ? id_q : '0;
    rsp_result = (state_q == S_DONE) ? res_q : 32'd0;
    busy       = (state_q != S_IDLE);
  end
endmodule

// File: tb/tb_fp_add_scheduler.sv
// tb/tb_fp_add_scheduler.sv - randomized self-checking bench for fp_add_scheduler
// Operands are small integers so every sum is exact and the reference needs only integer maths.
module tb_fp_add_scheduler;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid, req_ready, req_add_sub;
  logic [32*N-1:0] req_num1, req_num2;
  logic           rsp_valid, rsp_ready, busy;
  logic [1:0]     rsp_id;
  logic [31:0]    rsp_result;

  int checks = 0;
  int failures = 0;
  int ta [N];
  int tb [N];
  bit tsub [N];
  int m_phase, m_rr, m_id, last_grant, cyc;
  logic [31:0] m_res;
  int grant_q[$];
  int gcyc_q[$];

  fp_add_scheduler #(.N_REQ(N), .ID_W(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_num1(req_num1), .req_num2(req_num2), .req_add_sub(req_add_sub),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] int2fp(int v);
    logic [31:0] mu, mm;
    logic s;
    int e;
    if (v == 0) return 32'd0;
    s  = (v < 0);
    mu = s ? -v : v;
    e  = 0;
    for (int i = 0; i < 32; i++) if (mu[i]) e = i;
    mm = mu << (23 - e);
    return {s, 8'(127 + e), mm[22:0]};
  endfunction

  function automatic int rnd_val();
    int v;
    v = int'($urandom_range(0, 1 << 20));
    return ($urandom_range(0, 1) == 1) ? -v : v;
  endfunction

  task automatic set_req(int i, int a, int b, bit s, bit v);
    ta[i] = a; tb[i] = b; tsub[i] = s;
    req_num1[32*i +: 32] = int2fp(a);
    req_num2[32*i +: 32] = int2fp(b);
    req_add_sub[i] = s;
    req_valid[i] = v;
  endtask

  // One cycle: compare outputs against the reference, then advance it across the edge.
  task automatic step();
    logic [N-1:0] er;
    int g, idx, r;
    #1;
    er = '0;
    g = -1;
    if (m_phase == 0 && !rst) begin
      for (int k = 0; k < N; k++) begin
        idx = (m_rr + k) % N;
        if (g < 0 && req_valid[idx]) g = idx;
      end
    end
    if (g >= 0) er[g] = 1'b1;
    check("req_ready", 32'(req_ready), 32'(er));
    check("busy", 32'(busy), 32'(m_phase != 0));
    check("rsp_valid", 32'(rsp_valid), 32'(m_phase == 2));
    if (m_phase == 2) begin
      check("rsp_id", 32'(rsp_id), 32'(m_id));
      check("rsp_result", rsp_result, m_res);
    end
    last_grant = -1;
    if (rst) begin
      m_phase = 0;
      m_rr = 0;
    end else begin
      case (m_phase)
        0: if (g >= 0) begin
          r = tsub[g] ? ta[g] - tb[g] : ta[g] + tb[g];
          m_res = int2fp(r);
          m_id = g;
          m_rr = (g + 1) % N;
          m_phase = 1;
          last_grant = g;
          grant_q.push_back(g);
          gcyc_q.push_back(cyc);
        end
        1: m_phase = 2;
        default: if (rsp_ready) m_phase = 0;
      endcase
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic drain();
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (3) step();
  endtask

  initial begin
    logic [31:0] hold_res;
    logic [1:0]  hold_id;
    int n2;
    rst = 1'b1; rsp_ready = 1'b0;
    req_valid = '0; req_add_sub = '0; req_num1 = '0; req_num2 = '0;
    for (int i = 0; i < N; i++) begin ta[i] = 0; tb[i] = 0; tsub[i] = 0; end
    m_phase = 0; m_rr = 0; m_id = 0; m_res = 0; last_grant = -1; cyc = 0;
    @(negedge clk);
    step(); step();
    rst = 1'b0;
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_rsp_id", 32'(rsp_id), 32'd0);
    check("reset_rsp_result", rsp_result, 32'd0);
    check("reset_req_ready", 32'(req_ready), 32'd0);

    // single add from requester 1
    rsp_ready = 1'b1;
    set_req(1, 1, 2, 1'b0, 1'b1);
    #1 check("add_ready", 32'(req_ready), 32'h2);
    step();
    req_valid[1] = 1'b0;
    step();
    #1;
    check("add_valid", 32'(rsp_valid), 32'd1);
    check("add_id", 32'(rsp_id), 32'd1);
    check("add_result", rsp_result, 32'h40400000);
    step();

    // subtract from requester 0
    set_req(0, 3, 1, 1'b1, 1'b1);
    step();
    req_valid[0] = 1'b0;
    step();
    #1;
    check("sub_id", 32'(rsp_id), 32'd0);
    check("sub_result", rsp_result, 32'h40000000);
    step();

    // round-robin with every requester continuously valid
    rst = 1'b1; step(); rst = 1'b0;
    for (int i = 0; i < N; i++) set_req(i, 100 * (i + 1), i + 5, 1'b0, 1'b1);
    grant_q.delete(); gcyc_q.delete();
    for (int c = 0; c < 18; c++) begin
      step();
      if (last_grant >= 0) set_req(last_grant, rnd_val(), rnd_val(), 1'($urandom_range(0, 1)), 1'b1);
    end
    check("rr_count", 32'(grant_q.size()), 32'd6);
    if (grant_q.size() >= 6) begin
      for (int j = 0; j < 6; j++) check("rr_order", 32'(grant_q[j]), 32'(j % N));
      for (int j = 0; j < 5; j++) check("rr_spacing", 32'(gcyc_q[j+1] - gcyc_q[j]), 32'd3);
    end

    // backpressure in DONE
    drain();
    rsp_ready = 1'b0;
    set_req(2, 7, -3, 1'b0, 1'b1);
    step();
    req_valid[2] = 1'b0;
    set_req(0, 11, 4, 1'b1, 1'b1);
    set_req(1, 9, 9, 1'b0, 1'b1);
    step();
    #1;
    hold_res = rsp_result;
    hold_id  = rsp_id;
    check("bp_result", hold_res, int2fp(4));
    for (int c = 0; c < 5; c++) begin
      #1;
      check("bp_valid", 32'(rsp_valid), 32'd1);
      check("bp_id_stable", 32'(rsp_id), 32'(hold_id));
      check("bp_res_stable", rsp_result, hold_res);
      check("bp_no_ready", 32'(req_ready), 32'd0);
      step();
    end
    rsp_ready = 1'b1;
    step();
    #1 check("bp_next_grant", 32'(|req_ready), 32'd1);
    step();

    // reset during EXEC
    drain();
    set_req(3, 5, 6, 1'b0, 1'b1);
    step();
    req_valid[3] = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    set_req(2, 1, 1, 1'b0, 1'b1);
    set_req(3, 2, 2, 1'b0, 1'b1);
    #1;
    check("rstmid_busy", 32'(busy), 32'd0);
    check("rstmid_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rstmid_grant", 32'(req_ready), 32'h4);
    step();
    req_valid = '0;
    drain();

    // withdrawn request
    grant_q.delete();
    set_req(0, 8, 8, 1'b0, 1'b1);
    step();
    req_valid[0] = 1'b0;
    set_req(2, 4, 4, 1'b0, 1'b1);
    step();
    req_valid[2] = 1'b0;
    step();
    repeat (3) step();
    n2 = 0;
    foreach (grant_q[j]) if (grant_q[j] == 2) n2++;
    check("wd_no_grant2", 32'(n2), 32'd0);

    // randomized traffic
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (last_grant == i) begin
          if ($urandom_range(0, 1) == 1) set_req(i, rnd_val(), rnd_val(), 1'($urandom_range(0, 1)), 1'b1);
          else req_valid[i] = 1'b0;
        end else if (req_valid[i]) begin
          if ($urandom_range(0, 19) == 0) req_valid[i] = 1'b0;
        end else if ($urandom_range(0, 4) < 2) begin
          set_req(i, rnd_val(), rnd_val(), 1'($urandom_range(0, 1)), 1'b1);
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 99) == 0);
      step();
    end
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
